// File: rtl/ahb_apb_master_if.sv
// ahb_apb_master_if: bundles the command, response and APB signals of the
// command-to-APB bridge.
//   master modport - seen by the bridge (drives cmd_ready, rsp_*, APB requests)
//   slave  modport - seen by the command source / APB slave side
// Ports (all in the interface):
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata   command channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_error/rsp_timeout response channel
//   io_apb_P*                                           APB requester signals
interface ahb_apb_master_if #(
   parameter int ADDR_WIDTH = 4
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [31:0]           cmd_wdata;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [31:0]           rsp_rdata;
   logic                  rsp_error;
   logic                  rsp_timeout;

   logic [ADDR_WIDTH-1:0] io_apb_PADDR;
   logic                  io_apb_PSEL;
   logic                  io_apb_PENABLE;
   logic                  io_apb_PWRITE;
   logic [31:0]           io_apb_PWDATA;
   logic                  io_apb_PREADY;
   logic [31:0]           io_apb_PRDATA;
   logic                  io_apb_PSLVERROR;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
             io_apb_PREADY, io_apb_PRDATA, io_apb_PSLVERROR,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
             io_apb_PADDR, io_apb_PSEL, io_apb_PENABLE, io_apb_PWRITE, io_apb_PWDATA
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
             io_apb_PREADY, io_apb_PRDATA, io_apb_PSLVERROR,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
             io_apb_PADDR, io_apb_PSEL, io_apb_PENABLE, io_apb_PWRITE, io_apb_PWDATA
   );
endinterface

// File: rtl/ahb_apb_master.sv
// ahb_apb_master: turns single command/response transactions into APB
// transfers, with a bounded wait for PREADY.
// Ports:
//   io_ahb_PCLK   clock, rising edge
//   io_ahb_PRESET asynchronous active-high reset
//   bus           ahb_apb_master_if.master (command, response, APB)
//
// state  | meaning
// IDLE   | cmd_ready=1, waiting for a command
// SETUP  | APB setup phase, PSEL=1 PENABLE=0
// ACCESS | APB access phase, waiting for PREADY or timeout
// RESP   | rsp_valid=1, holding response until rsp_ready
module ahb_apb_master #(
   parameter int ADDR_WIDTH = 4,
   parameter int TIMEOUT    = 16
) (
   input logic               io_ahb_PCLK,
   input logic               io_ahb_PRESET,
   ahb_apb_master_if.master  bus
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   localparam logic [7:0] LP_CNT_TC = 8'(TIMEOUT - 1);

   state_t                r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
   logic                  r_write, w_write_nxt;
   logic [31:0]           r_wdata, w_wdata_nxt;
   logic [31:0]           r_rdata, w_rdata_nxt;
   logic                  r_error, w_error_nxt;
   logic                  r_timeout, w_timeout_nxt;
   logic [7:0]            r_cnt, w_cnt_nxt;

   always_ff @(posedge io_ahb_PCLK or posedge io_ahb_PRESET) begin
      if (io_ahb_PRESET) begin
         r_state   <= IDLE;
         r_addr    <= '0;
         r_write   <= 1'b0;
         r_wdata   <= '0;
         r_rdata   <= '0;
         r_error   <= 1'b0;
         r_timeout <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_addr    <= w_addr_nxt;
         r_write   <= w_write_nxt;
         r_wdata   <= w_wdata_nxt;
         r_rdata   <= w_rdata_nxt;
         r_error   <= w_error_nxt;
         r_timeout <= w_timeout_nxt;
         r_cnt     <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_addr_nxt    = r_addr;
      w_write_nxt   = r_write;
      w_wdata_nxt   = r_wdata;
      w_rdata_nxt   = r_rdata;
      w_error_nxt   = r_error;
      w_timeout_nxt = r_timeout;
      w_cnt_nxt     = r_cnt;
      unique case (r_state)
         IDLE: begin
            if (bus.cmd_valid) begin
               w_addr_nxt  = bus.cmd_addr;
               w_write_nxt = bus.cmd_write;
               w_wdata_nxt = bus.cmd_wdata;
               w_state_nxt = SETUP;
            end
         end
         SETUP: begin
            // clearing here means the counter reads 0 in the first ACCESS cycle
            w_cnt_nxt   = '0;
            w_state_nxt = ACCESS;
         end
         ACCESS: begin
            if (bus.io_apb_PREADY) begin
               w_rdata_nxt   = r_write ? 32'h0 : bus.io_apb_PRDATA;
               w_error_nxt   = bus.io_apb_PSLVERROR;
               w_timeout_nxt = 1'b0;
               w_state_nxt   = RESP;
            end else if (r_cnt == LP_CNT_TC) begin
               w_rdata_nxt   = 32'h0;
               w_error_nxt   = 1'b1;
               w_timeout_nxt = 1'b1;
               w_state_nxt   = RESP;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         RESP: begin
            if (bus.rsp_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign bus.cmd_ready      = (r_state == IDLE);
   assign bus.rsp_valid      = (r_state == RESP);
   assign bus.rsp_rdata      = r_rdata;
   assign bus.rsp_error      = r_error;
   assign bus.rsp_timeout    = r_timeout;
   assign bus.io_apb_PSEL    = (r_state == SETUP) || (r_state == ACCESS);
   assign bus.io_apb_PENABLE = (r_state == ACCESS);
   assign bus.io_apb_PADDR   = r_addr;
   assign bus.io_apb_PWRITE  = r_write;
   assign bus.io_apb_PWDATA  = r_wdata;
endmodule

// File: tb/tb_ahb_apb_master.sv
// tb_ahb_apb_master: random and directed transactions against a
// transaction-level reference model of the bridge.
module tb_ahb_apb_master;
   localparam int AW = 4;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   ahb_apb_master_if #(.ADDR_WIDTH(AW)) bus ();

   ahb_apb_master #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
      .io_ahb_PCLK   (clk),
      .io_ahb_PRESET (rst),
      .bus           (bus.master)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic drive_idle_inputs();
      bus.io_apb_PREADY    = 1'($urandom);
      bus.io_apb_PSLVERROR = 1'($urandom);
      bus.io_apb_PRDATA    = $urandom;
   endtask

   // One full transaction. waits = PREADY=0 cycles before the slave answers,
   // stall = cycles rsp_ready is held low (with cmd_valid high) in RESP.
   task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [31:0] wdata,
                          input logic [31:0] sdata, input int waits, input bit serr, input int stall);
      int  cyc;
      int  k;
      bit  got;
      int  exp_acc;
      bit  exp_to;
      logic [31:0] exp_rdata;
      exp_to    = (waits >= TO);
      exp_acc   = exp_to ? TO : waits + 1;
      exp_rdata = (exp_to || wr) ? 32'h0 : sdata;

      check_eq("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wdata;
      bus.rsp_ready = 1'b0;
      drive_idle_inputs();
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'($urandom);
      bus.cmd_addr  = AW'($urandom);
      bus.cmd_wdata = $urandom;

      check_eq("setup_psel",    32'(bus.io_apb_PSEL),    32'd1);
      check_eq("setup_penable", 32'(bus.io_apb_PENABLE), 32'd0);
      check_eq("setup_paddr",   32'(bus.io_apb_PADDR),   32'(addr));
      check_eq("setup_pwrite",  32'(bus.io_apb_PWRITE),  32'(wr));
      check_eq("setup_pwdata",  bus.io_apb_PWDATA,       wdata);

      cyc = 1; k = 0; got = 0;
      while (!got && cyc < 60) begin
         if (bus.io_apb_PSEL && bus.io_apb_PENABLE) begin
            k++;
            if (bus.io_apb_PADDR !== addr || bus.io_apb_PWDATA !== wdata || bus.io_apb_PWRITE !== wr)
               check_eq("access_stable", {bus.io_apb_PWRITE, 27'(bus.io_apb_PADDR)}, {wr, 27'(addr)});
            if (k > waits) begin
               bus.io_apb_PREADY    = 1'b1;
               bus.io_apb_PSLVERROR = serr;
               bus.io_apb_PRDATA    = sdata;
            end else begin
               bus.io_apb_PREADY    = 1'b0;
               bus.io_apb_PSLVERROR = 1'($urandom);
               bus.io_apb_PRDATA    = $urandom;
            end
         end else begin
            drive_idle_inputs();
         end
         @(posedge clk); #1;
         cyc++;
         if (bus.rsp_valid) got = 1;
      end
      if (!got) begin
         check_eq("rsp_valid_budget", 32'd0, 32'd1);
         return;
      end
      drive_idle_inputs();
      check_eq("latency",      32'(cyc), 32'(2 + exp_acc));
      check_eq("access_cycles", 32'(k),  32'(exp_acc));
      check_eq("resp_psel",    32'({bus.io_apb_PSEL, bus.io_apb_PENABLE}), 32'd0);
      check_eq("rsp_rdata",    bus.rsp_rdata, exp_rdata);
      check_eq("rsp_error",    32'(bus.rsp_error),   32'(exp_to || serr));
      check_eq("rsp_timeout",  32'(bus.rsp_timeout), 32'(exp_to));

      for (int i = 0; i < stall; i++) begin
         bus.cmd_valid = 1'b1;
         bus.cmd_addr  = AW'($urandom);
         bus.cmd_wdata = $urandom;
         drive_idle_inputs();
         @(posedge clk); #1;
         check_eq("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         check_eq("stall_cmd_ready", 32'(bus.cmd_ready), 32'd0);
         check_eq("stall_rsp", {bus.rsp_rdata[29:0], bus.rsp_error, bus.rsp_timeout},
                  {exp_rdata[29:0], 1'(exp_to || serr), exp_to});
         check_eq("stall_psel", 32'(bus.io_apb_PSEL), 32'd0);
      end
      // cmd_valid stays high across the consuming edge; it must not be taken
      bus.cmd_valid = 1'b1;
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      bus.cmd_valid = 1'b0;
      check_eq("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_eq("post_cmd_ready", 32'(bus.cmd_ready), 32'd1);
   endtask

   initial begin
      int cyc;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.rsp_ready = 1'b0;
      bus.io_apb_PREADY    = 1'b0;
      bus.io_apb_PRDATA    = '0;
      bus.io_apb_PSLVERROR = 1'b0;
      #23;
      check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check_eq("rst_psel",      32'({bus.io_apb_PSEL, bus.io_apb_PENABLE}), 32'd0);
      check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_eq("rst_rsp",       {bus.rsp_rdata[29:0], bus.rsp_error, bus.rsp_timeout}, 32'd0);
      check_eq("rst_paddr",     32'(bus.io_apb_PADDR), 32'd0);
      check_eq("rst_pwdata",    bus.io_apb_PWDATA, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_txn(1'b1, 4'd5, 32'hA5A5_0001, 32'h1234_5678, 0,  1'b0, 0);
      run_txn(1'b0, 4'd4, 32'h0,         32'hFFFF_FFFF, 3,  1'b0, 0);
      run_txn(1'b0, 4'd9, 32'h0,         32'hDEAD_BEEF, 40, 1'b0, 1);
      run_txn(1'b1, 4'd2, 32'h0000_00FF, 32'h0,         2,  1'b1, 0);
      run_txn(1'b0, 4'd7, 32'h0,         32'h0BAD_F00D, TO - 1, 1'b0, 5);
      run_txn(1'b0, 4'd1, 32'h0,         32'h5555_AAAA, TO, 1'b1, 5);

      for (int t = 0; t < 40; t++)
         run_txn(1'($urandom), AW'($urandom), $urandom, $urandom,
                 int'($urandom_range(0, 20)), 1'($urandom), int'($urandom_range(0, 3)));

      // reset while the slave is stalling in ACCESS
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 4'hC;
      bus.cmd_wdata = 32'h1111_2222;
      bus.io_apb_PREADY = 1'b0;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      cyc = 0;
      while (!(bus.io_apb_PSEL && bus.io_apb_PENABLE) && cyc < 10) begin
         @(posedge clk); #1;
         cyc++;
      end
      check_eq("reach_access", 32'(bus.io_apb_PENABLE), 32'd1);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check_eq("mid_rst_psel",      32'({bus.io_apb_PSEL, bus.io_apb_PENABLE}), 32'd0);
      check_eq("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_eq("mid_rst_regs",      {bus.io_apb_PWDATA[27:0], bus.io_apb_PADDR}, 32'd0);
      @(posedge clk); #2;
      rst = 1'b0;
      @(posedge clk); #1;
      check_eq("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check_eq("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_eq("post_rst_psel",      32'(bus.io_apb_PSEL), 32'd0);
      run_txn(1'b0, 4'd3, 32'h0, 32'hCAFE_0003, 1, 1'b0, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
